ecc_err_rdout: RTL

ECC_ERR_RDOUT -- requirements
Module: ecc_err_rdout

---
 rtl/ecc_mon_pkg.sv | 32 +++
 rtl/ecc_err_rdout_if.sv | 24 ++
 rtl/ecc_sat_cnt.sv | 26 ++
 rtl/ecc_err_rdout.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_mon_pkg.sv
// rtl/ecc_mon_pkg.sv - readout word layout and scanner state encoding
package ecc_mon_pkg;

    localparam int WORD_W      = 32;
    localparam int IDX_MSB     = 31;
    localparam int IDX_LSB     = 22;
    localparam int RSV_MSB     = 21;
    localparam int RSV_LSB     = 16;
    localparam int CNT_MSB     = 15;
    localparam int CNT_LSB     = 0;
    localparam int IDX_FIELD_W = IDX_MSB - IDX_LSB + 1;
    localparam int CNT_FIELD_W = CNT_MSB - CNT_LSB + 1;

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_EMIT = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    // Pack an index and a count into one readout word; reserved bits stay zero.
    function automatic logic [WORD_W-1:0] make_word(
        input logic [IDX_FIELD_W-1:0] idx,
        input logic [CNT_FIELD_W-1:0] cnt
    );
        logic [WORD_W-1:0] w;
        w                   = '0;
        w[IDX_MSB:IDX_LSB]  = idx;
        w[CNT_MSB:CNT_LSB]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/ecc_err_rdout_if.sv
// rtl/ecc_err_rdout_if.sv - downstream readout FIFO write port
interface ecc_err_rdout_if;
    import ecc_mon_pkg::*;

    logic              fifo_wr_o;
    logic [WORD_W-1:0] fifo_data_o;
    logic              fifo_full_i;
    logic              fifo_almst_full_i;

    modport master (
        output fifo_wr_o,
        output fifo_data_o,
        input  fifo_full_i,
        input  fifo_almst_full_i
    );

    modport slave (
        input  fifo_wr_o,
        input  fifo_data_o,
        output fifo_full_i,
        output fifo_almst_full_i
    );

endinterface

// File: rtl/ecc_sat_cnt.sv
// rtl/ecc_sat_cnt.sv - saturating event counter with synchronous clear
module ecc_sat_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    assign sat = (cnt == CNT_MAX);

    // Count up on inc, stick at all-ones; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ecc_err_rdout.sv
// rtl/ecc_err_rdout.sv - per-bit ECC error counters with scanned FIFO readout
module ecc_err_rdout
    import ecc_mon_pkg::*;
#(
    parameter int K      = 384,
    parameter int CW     = 16,
    parameter int PERIOD = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [K-1:0]     monitor_i,
    input  logic             clear_i,
    ecc_err_rdout_if.master  fifo,
    output logic             err_any_o,
    output logic             sat_o
);

    localparam int              PW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [PW-1:0]   PTR_LAST = PW'(K - 1);
    localparam logic [23:0]     T_LAST   = 24'(PERIOD - 1);

    logic [CW-1:0] cnt [K];
    logic [K-1:0]  at_max;
    logic [K-1:0]  nonzero;
    logic [K-1:0]  pend;
    logic [K-1:0]  pend_clr;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nx;
    logic [PW-1:0] ptr_adv;
    logic          at_last;
    logic          backpressure;
    logic          wr;
    logic          dump_take;
    logic          dump_req;
    logic          timer_hit;
    logic [23:0]   timer;

    for (genvar g = 0; g < K; g++) begin : g_cnt
        ecc_sat_cnt #(
            .CW (CW)
        ) u_cnt (
            .clk (clk_i),
            .rst (rst_i),
            .clr (clear_i),
            .inc (monitor_i[g]),
            .cnt (cnt[g]),
            .sat (at_max[g])
        );
        assign nonzero[g] = |cnt[g];
    end

    assign backpressure = fifo.fifo_full_i | fifo.fifo_almst_full_i;
    assign at_last      = (ptr == PTR_LAST);
    assign ptr_adv      = at_last ? '0 : ptr + PW'(1);

    // A reset cycle never writes, even if the FSM register still holds EMIT/DUMP.
    assign fifo.fifo_wr_o   = wr & ~rst_i;
    assign fifo.fifo_data_o = fifo.fifo_wr_o
                            ? make_word(IDX_FIELD_W'(ptr), CNT_FIELD_W'(cnt[ptr]))
                            : '0;

    // The index being written loses its pending flag, unless it increments again.
    assign pend_clr = fifo.fifo_wr_o ? (K'(1) << ptr) : '0;

    // Next-state and write decode for the scan / emit / dump sequencer.
    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        wr        = 1'b0;
        dump_take = 1'b0;
        case (state)
            ST_SCAN: begin
                if (pend[ptr] && !backpressure) begin
                    state_nx = ST_EMIT;
                end else begin
                    ptr_nx = ptr_adv;
                    if (at_last && dump_req) begin
                        state_nx  = ST_DUMP;
                        dump_take = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                // Space was reserved by almost-full when EMIT was entered.
                wr       = 1'b1;
                ptr_nx   = ptr_adv;
                state_nx = ST_SCAN;
                if (at_last && dump_req) begin
                    state_nx  = ST_DUMP;
                    dump_take = 1'b1;
                end
            end
            ST_DUMP: begin
                if (!backpressure) begin
                    wr     = 1'b1;
                    ptr_nx = ptr_adv;
                    if (at_last) begin
                        state_nx = ST_SCAN;
                    end
                end
            end
            default: begin
                state_nx = ST_SCAN;
                ptr_nx   = '0;
            end
        endcase
        // Clear restarts scanning from index 0; an EMIT word still goes out, a dump word does not.
        if (clear_i) begin
            state_nx  = ST_SCAN;
            ptr_nx    = '0;
            dump_take = 1'b0;
            if (state == ST_DUMP) begin
                wr = 1'b0;
            end
        end
    end

    // Sequencer state and scan pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_SCAN;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Pending flags: set by any event, cleared when that index is written out.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | monitor_i;
        end
    end

    // Sticky saturation: an event landing on a counter already at full scale.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            sat_o <= 1'b0;
        end else if (|(monitor_i & at_max)) begin
            sat_o <= 1'b1;
        end
    end

    // Any-error summary, registered one cycle behind the counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_any_o <= 1'b0;
        end else begin
            err_any_o <= |nonzero;
        end
    end

    assign timer_hit = (PERIOD != 0) && (timer == T_LAST);

    // Free-running dump interval timer; idle at zero when dumps are disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || timer_hit) begin
            timer <= '0;
        end else if (PERIOD != 0) begin
            timer <= timer + 24'd1;
        end
    end

    // Dump request waits for the next pointer wrap; a new expiry during a dump is kept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dump_req <= 1'b0;
        end else if (timer_hit) begin
            dump_req <= 1'b1;
        end else if (dump_take) begin
            dump_req <= 1'b0;
        end
    end

endmodule
